scan_capture: RTL and testbench
===============================

Name: scan_capture

Overview:
- Receive-side counterpart of the matrix display driver: samples the multiplexed row/column scan (one-hot row select plus column pattern) and rebuilds the gs x gs frame.
- Uses the same enable/done handshake as the other blocks, so the top-level controller can sequence it like get_input/action/display.
- Used for on-chip self-check of the display path and as the input stage of a chained board.

Parameters:
- gs, 8, grid size; the frame is gs x gs pixels.
- hold, 2, number of consecutive identical samples required before a row is accepted (glitch filter), legal range 1..15.
- to_cyc, 1024, number of cycles in scan mode without completing a frame before timeout, legal range 2..65535.

Ports:
- clk_i  in  1  clock; all registers update on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- e_cap_i  in  1  enable (level); high requests capture of one frame.
- row_val_i  in  gs  scanned row select; active-high, one-hot when driven, all-zero means blanking.
- col_val_i  in  gs  column pattern of the selected row; bit c=1 means pixel on.
- matrix_o  out  gs*gs  last published frame; bit r*gs+c is row r, column c.
- rows_seen_o  out  gs  rows captured since the current enable.
- d_cap_o  out  1  done; high from completion until e_cap_i falls.
- err_o  out  1  sticky error (multi-hot row or timeout); cleared at the next capture start.

Behaviour:
- Reset (rst_i=1 at an edge): matrix_o=0, rows_seen_o=0, d_cap_o=0, err_o=0, internal shadow frame=0, counters=0, state IDLE. Applies from any state and overrides all other inputs.
- States: IDLE, SCAN, DONE.
- IDLE:
  - d_cap_o=0.
  - On e_cap_i=1: clear rows_seen_o, err_o, the stability counter, the previous-sample register and the timeout counter, then go to SCAN.
  - Sampling starts on the first SCAN cycle.
- SCAN, each cycle, sample row_val_i/col_val_i:
  - Zero row: stability counter reset to 0; no error.
  - More than one row bit set: err_o<=1; stability counter reset to 0; nothing written; scanning continues.
  - One-hot row: if (row, col) equals the previous one-hot sample, the counter increments, saturating at hold; otherwise the counter is set to 1.
  - Row acceptance: on the cycle the counter first reaches hold, shadow row r <= col_val_i and rows_seen_o[r] <= 1. hold=1 accepts on the first sample.
  - Re-capture: an already-seen row is overwritten by the newer accepted value.
  - Timeout counter increments every SCAN cycle.
- Completion:
  - When the accepting write makes rows_seen all ones, at the same edge: matrix_o <= shadow including that write, d_cap_o <= 1, state DONE.
  - Latency is 0 cycles after the accepting sample edge; d_cap_o is visible in the following cycle.
- Timeout:
  - If the timeout counter reaches to_cyc-1 without completion: err_o <= 1, d_cap_o <= 1, go to DONE.
  - matrix_o is NOT updated, so the previous frame is kept.
  - Completion and timeout at the same edge: completion wins and err_o is unchanged.
- DONE:
  - Hold d_cap_o=1 and all outputs stable while e_cap_i=1.
  - When e_cap_i=0: d_cap_o <= 0, go to IDLE.
- Abort: e_cap_i=0 while in SCAN → IDLE next edge, d_cap_o stays 0, matrix_o unchanged, rows_seen_o and err_o keep their values.
- Enable held high after DONE→IDLE cannot occur: leaving DONE requires e_cap_i=0.
- Width rules:
  - Stability counter is 4 bits.
  - Timeout counter is clog2(to_cyc) bits and never wraps inside SCAN.
  - The shadow frame is a separate gs*gs register; matrix_o is a published copy, so there are no partial-frame updates.

Test Plan:
- Full frame: e_cap_i=1, drive rows 0..7 one-hot with col=8'h81,8'h42,...,8'h18, each for 3 cycles, hold=2 → d_cap_o rises the cycle after row 7's second sample; matrix_o matches the pattern; err_o=0; rows_seen_o=8'hFF.
- Glitch filter: row 3 with col=8'hFF for 1 cycle, then row 3 with col=8'h0F for 2 cycles → row 3 of matrix_o = 8'h0F after completion.
- Multi-hot: row_val=8'h06 for 2 cycles mid-frame, then a valid full scan → err_o=1, d_cap_o=1, frame still published.
- Timeout: to_cyc=16, only rows 0..5 driven → at SCAN cycle 15 err_o=1, d_cap_o=1, matrix_o still equals the previous frame; e_cap_i=0 → d_cap_o=0 next edge.
- Abort/reset: drop e_cap_i after 4 rows → IDLE with matrix_o unchanged. Repeat with rst_i=1 for one edge mid-SCAN → all outputs 0 and IDLE.
- Back-to-back: two enables with frames A and B, e_cap_i low for 1 cycle between them → matrix_o=A, then B; rows_seen_o cleared at the second start.

Source files
------------

// File: rtl/scan_capture.sv
// rtl/scan_capture.sv - rebuilds a gs x gs frame from a multiplexed row/column scan
//
// Samples a one-hot row select plus its column pattern and assembles the rows
// into a shadow frame, with a glitch filter that only accepts a row once the
// same sample has been seen hold times in a row. When every row has been
// accepted the shadow frame is published to matrix_o in one step. Uses the
// enable/done handshake so a controller can sequence it like the other blocks.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   e_cap_i      enable level; high requests capture of one frame
//   row_val_i    scanned row select (one-hot, all-zero = blanking)
//   col_val_i    column pattern of the selected row
//   matrix_o     last published frame, bit r*gs+c = row r, column c
//   rows_seen_o  rows accepted since the current enable
//   d_cap_o      done, high from completion until e_cap_i falls
//   err_o        sticky error (multi-hot row or timeout)

module scan_capture #(
    parameter int gs     = 8,
    parameter int hold   = 2,
    parameter int to_cyc = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               e_cap_i,
    input  logic [gs-1:0]      row_val_i,
    input  logic [gs-1:0]      col_val_i,
    output logic [gs*gs-1:0]   matrix_o,
    output logic [gs-1:0]      rows_seen_o,
    output logic               d_cap_o,
    output logic               err_o
);

    localparam int tw = $clog2(to_cyc);
    localparam logic [3:0]    hold_c  = 4'(hold);
    localparam logic [tw-1:0] to_last = tw'(to_cyc - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [gs*gs-1:0]  shadow, shadow_nxt, matrix_nxt;
    logic [gs-1:0]     rows_seen_nxt;
    logic [gs-1:0]     prev_row, prev_row_nxt;
    logic [gs-1:0]     prev_col, prev_col_nxt;
    logic [3:0]        stab, stab_nxt;
    logic [tw-1:0]     to_cnt, to_cnt_nxt;
    logic              d_cap_nxt, err_nxt;

    logic              row_zero;
    logic              row_onehot;
    logic              same;
    logic              accept;
    // rows_seen / shadow as they look including this cycle's accepted row,
    // so completion can publish the row that finishes the frame at once
    logic [gs-1:0]     seen_upd;
    logic [gs*gs-1:0]  shadow_upd;

    assign row_zero   = (row_val_i == '0);
    // x & (x-1) clears the lowest set bit; zero result means at most one bit set
    assign row_onehot = !row_zero && ((row_val_i & (row_val_i - gs'(1))) == '0);
    assign same       = (row_val_i == prev_row) && (col_val_i == prev_col);

    always_comb begin
        state_nxt     = state;
        shadow_nxt    = shadow;
        matrix_nxt    = matrix_o;
        rows_seen_nxt = rows_seen_o;
        prev_row_nxt  = prev_row;
        prev_col_nxt  = prev_col;
        stab_nxt      = stab;
        to_cnt_nxt    = to_cnt;
        d_cap_nxt     = d_cap_o;
        err_nxt       = err_o;
        accept        = 1'b0;
        seen_upd      = rows_seen_o;
        shadow_upd    = shadow;

        case (state)
            IDLE: begin
                d_cap_nxt = 1'b0;
                if (e_cap_i) begin
                    rows_seen_nxt = '0;
                    err_nxt       = 1'b0;
                    stab_nxt      = 4'd0;
                    prev_row_nxt  = '0;
                    prev_col_nxt  = '0;
                    to_cnt_nxt    = '0;
                    state_nxt     = SCAN;
                end
            end

            SCAN: begin
                if (!e_cap_i) begin
                    // abort: keep rows_seen/err for inspection, publish nothing
                    state_nxt = IDLE;
                end else begin
                    // stop short of the last value so the counter cannot wrap
                    if (to_cnt != to_last) begin
                        to_cnt_nxt = to_cnt + tw'(1);
                    end

                    if (row_zero) begin
                        stab_nxt = 4'd0;
                    end else if (!row_onehot) begin
                        err_nxt  = 1'b1;
                        stab_nxt = 4'd0;
                    end else begin
                        prev_row_nxt = row_val_i;
                        prev_col_nxt = col_val_i;
                        if (same) begin
                            stab_nxt = (stab >= hold_c) ? hold_c : stab + 4'd1;
                        end else begin
                            stab_nxt = 4'd1;
                        end
                        // accept only on the transition into hold, not while saturated
                        accept = (stab_nxt == hold_c) && !(same && (stab == hold_c));
                        if (accept) begin
                            for (int r = 0; r < gs; r++) begin
                                if (row_val_i[r]) begin
                                    shadow_upd[r*gs +: gs] = col_val_i;
                                    seen_upd[r]            = 1'b1;
                                end
                            end
                            shadow_nxt    = shadow_upd;
                            rows_seen_nxt = seen_upd;
                        end
                    end

                    // completion takes priority over a timeout on the same edge
                    if (accept && (&seen_upd)) begin
                        matrix_nxt = shadow_upd;
                        d_cap_nxt  = 1'b1;
                        state_nxt  = DONE;
                    end else if (to_cnt == to_last) begin
                        err_nxt   = 1'b1;
                        d_cap_nxt = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                if (!e_cap_i) begin
                    d_cap_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            shadow      <= '0;
            matrix_o    <= '0;
            rows_seen_o <= '0;
            prev_row    <= '0;
            prev_col    <= '0;
            stab        <= 4'd0;
            to_cnt      <= '0;
            d_cap_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            matrix_o    <= matrix_nxt;
            rows_seen_o <= rows_seen_nxt;
            prev_row    <= prev_row_nxt;
            prev_col    <= prev_col_nxt;
            stab        <= stab_nxt;
            to_cnt      <= to_cnt_nxt;
            d_cap_o     <= d_cap_nxt;
            err_o       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_scan_capture.sv
// tb/tb_scan_capture.sv - self-checking bench for scan_capture

module tb_scan_capture;

    localparam int GS     = 8;
    localparam int HOLD   = 2;
    localparam int TO_CYC = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            e_cap = 1'b0;
    logic [GS-1:0]   row_val = '0;
    logic [GS-1:0]   col_val = '0;
    logic [GS*GS-1:0] matrix;
    logic [GS-1:0]   rows_seen;
    logic            d_cap;
    logic            err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [GS*GS-1:0] m;
        logic             e;
        logic [GS-1:0]    rs;
    } exp_t;

    exp_t exp_q[$];

    scan_capture #(.gs(GS), .hold(HOLD), .to_cyc(TO_CYC)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .e_cap_i     (e_cap),
        .row_val_i   (row_val),
        .col_val_i   (col_val),
        .matrix_o    (matrix),
        .rows_seen_o (rows_seen),
        .d_cap_o     (d_cap),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] col_of(input int which, input int r);
        logic [7:0] one;
        logic [7:0] top;
        one = 8'h01;
        top = 8'h80;
        case (which)
            0:       col_of = (one << r) | (top >> r);
            1:       col_of = 8'(r * 37 + 5);
            default: col_of = ~((one << r) | (top >> r)) ^ 8'(r);
        endcase
    endfunction

    function automatic logic [GS*GS-1:0] frame_of(input int which);
        logic [GS*GS-1:0] f;
        f = '0;
        for (int r = 0; r < GS; r++) f[r*GS +: GS] = col_of(which, r);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] row, input logic [7:0] col, input int n);
        row_val = row;
        col_val = col;
        repeat (n) tick();
    endtask

    task automatic start_cap();
        e_cap   = 1'b1;
        row_val = '0;
        col_val = '0;
        tick();
    endtask

    task automatic scan_rows(input int which, input int first, input int last, input int n);
        logic [7:0] one;
        one = 8'h01;
        for (int r = first; r <= last; r++) drive(one << r, col_of(which, r), n);
    endtask

    // wait for done, then compare against the oldest expected frame
    task automatic check_output(input string name);
        int   n;
        exp_t ex;
        n = 0;
        while (!d_cap && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_queue: got empty scoreboard, need an entry", name);
            return;
        end
        ex = exp_q.pop_front();
        if (d_cap !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: got d_cap=%b need 1 within budget", name, d_cap);
            return;
        end
        total++;
        if (matrix !== ex.m) begin
            bad++;
            $display("FAIL %s_matrix: got %h need %h", name, matrix, ex.m);
        end
        total++;
        if (err !== ex.e) begin
            bad++;
            $display("FAIL %s_err: got %b need %b", name, err, ex.e);
        end
        total++;
        if (rows_seen !== ex.rs) begin
            bad++;
            $display("FAIL %s_rows: got %h need %h", name, rows_seen, ex.rs);
        end
    endtask

    task automatic end_cap(input string name);
        e_cap = 1'b0;
        tick();
        total++;
        if (d_cap !== 1'b0) begin
            bad++;
            $display("FAIL %s_release: got d_cap=%b need 0", name, d_cap);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({matrix, rows_seen, d_cap, err} !== '0) begin
            bad++;
            $display("FAIL reset_state: got m=%h rs=%h d=%b e=%b need all 0",
                     matrix, rows_seen, d_cap, err);
        end
    endtask

    task automatic test_full_frame();
        start_cap();
        exp_q.push_back('{m: frame_of(0), e: 1'b0, rs: 8'hFF});
        scan_rows(0, 0, 6, 3);
        drive(8'h80, col_of(0, 7), 1);
        total++;
        if (d_cap !== 1'b0) begin
            bad++;
            $display("FAIL full_early_done: got d_cap=%b need 0", d_cap);
        end
        drive(8'h80, col_of(0, 7), 1);
        total++;
        if (d_cap !== 1'b1) begin
            bad++;
            $display("FAIL full_latency: got d_cap=%b need 1", d_cap);
        end
        drive(8'h80, col_of(0, 7), 1);
        check_output("full");
        end_cap("full");
    endtask

    task automatic test_glitch();
        logic [GS*GS-1:0] f;
        f = frame_of(1);
        f[3*GS +: GS] = 8'h0F;
        start_cap();
        exp_q.push_back('{m: f, e: 1'b0, rs: 8'hFF});
        scan_rows(1, 0, 2, 2);
        drive(8'h08, 8'hFF, 1);
        drive(8'h08, 8'h0F, 2);
        scan_rows(1, 4, 7, 2);
        check_output("glitch");
        end_cap("glitch");
    endtask

    task automatic test_multi_hot();
        start_cap();
        exp_q.push_back('{m: frame_of(2), e: 1'b1, rs: 8'hFF});
        scan_rows(1, 0, 3, 2);
        drive(8'h06, 8'hAA, 2);
        scan_rows(2, 0, 7, 2);
        check_output("multihot");
        end_cap("multihot");
    endtask

    task automatic test_timeout();
        start_cap();
        exp_q.push_back('{m: frame_of(2), e: 1'b1, rs: 8'h3F});
        scan_rows(0, 0, 5, 2);
        drive(8'h00, 8'h00, TO_CYC - 12 - 1);
        total++;
        if (d_cap !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got d_cap=%b need 0", d_cap);
        end
        drive(8'h00, 8'h00, 1);
        check_output("timeout");
        end_cap("timeout");
    endtask

    // last row accepted on the same edge the timeout would fire
    task automatic test_collision();
        start_cap();
        exp_q.push_back('{m: frame_of(0), e: 1'b0, rs: 8'hFF});
        drive(8'h00, 8'h00, TO_CYC - 16);
        scan_rows(0, 0, 6, 2);
        drive(8'h80, col_of(0, 7), 1);
        total++;
        if (d_cap !== 1'b0) begin
            bad++;
            $display("FAIL collide_early: got d_cap=%b need 0", d_cap);
        end
        drive(8'h80, col_of(0, 7), 1);
        check_output("collide");
        end_cap("collide");
    endtask

    task automatic test_abort();
        start_cap();
        scan_rows(1, 0, 3, 2);
        e_cap = 1'b0;
        tick();
        total++;
        if ({d_cap, err, rows_seen} !== {1'b0, 1'b0, 8'h0F} || matrix !== frame_of(0)) begin
            bad++;
            $display("FAIL abort_state: got d=%b e=%b rs=%h m=%h need 0 0 0f %h",
                     d_cap, err, rows_seen, matrix, frame_of(0));
        end
        start_cap();
        total++;
        if (rows_seen !== 8'h00) begin
            bad++;
            $display("FAIL restart_clear: got rs=%h need 00", rows_seen);
        end
        scan_rows(1, 0, 1, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e_cap = 1'b0;
        total++;
        if ({matrix, rows_seen, d_cap, err} !== '0) begin
            bad++;
            $display("FAIL midscan_reset: got m=%h rs=%h d=%b e=%b need all 0",
                     matrix, rows_seen, d_cap, err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        start_cap();
        exp_q.push_back('{m: frame_of(1), e: 1'b0, rs: 8'hFF});
        scan_rows(1, 0, 7, 2);
        check_output("b2b_a");
        e_cap = 1'b0;
        tick();
        start_cap();
        total++;
        if (rows_seen !== 8'h00 || d_cap !== 1'b0 || matrix !== frame_of(1)) begin
            bad++;
            $display("FAIL b2b_start: got rs=%h d=%b m=%h need 00 0 %h",
                     rows_seen, d_cap, matrix, frame_of(1));
        end
        exp_q.push_back('{m: frame_of(2), e: 1'b0, rs: 8'hFF});
        scan_rows(2, 0, 7, 2);
        check_output("b2b_b");
        end_cap("b2b");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_glitch();
        test_multi_hot();
        test_timeout();
        test_collision();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
